// File: rtl/stage_pipe_hs.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid buffer,
// flush / trap-kill handling and a saturating count of killed beats.
module stage_pipe_hs #(
    parameter int                 WIDTH     = 221,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter bit                 SKID      = 1'b1,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              trap_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  kill_cnt
);

    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q,  m_data_d;
    logic             s_valid_q, s_valid_d;
    logic [WIDTH-1:0] s_data_q,  s_data_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] kill_cnt_q, kill_cnt_d;

    logic             accept, deliver, kill_all, take;
    logic [1:0]       kill_inc;
    logic [CNT_W:0]   kill_sum;

    assign in_ready  = SKID ? in_ready_q : (~m_valid_q | out_ready);
    assign accept    = in_valid & in_ready;
    assign deliver   = m_valid_q & out_ready;
    assign kill_all  = flush | (trap_en & out_ready);
    // A stalled trap keeps held beats but must still swallow the incoming one.
    assign take      = accept & ~trap_en;

    always_comb begin
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        s_valid_d  = s_valid_q;
        s_data_d   = s_data_q;
        kill_inc   = 2'd0;
        if (kill_all) begin
            m_valid_d = 1'b0;
            m_data_d  = RESET_VAL;
            s_valid_d = 1'b0;
            s_data_d  = RESET_VAL;
            // The beat leaving on this edge reached the consumer, so it is not a kill.
            kill_inc  = 2'(m_valid_q & ~deliver) + 2'(s_valid_q) + 2'(accept);
        end else begin
            kill_inc = 2'(accept & trap_en);
            if (!m_valid_q) begin
                if (take) begin
                    m_valid_d = 1'b1;
                    m_data_d  = in_data;
                end
            end else if (!s_valid_q) begin
                if (take && deliver) begin
                    m_data_d = in_data;
                end else if (take && SKID) begin
                    s_valid_d = 1'b1;
                    s_data_d  = in_data;
                end else if (deliver) begin
                    m_valid_d = 1'b0;
                    m_data_d  = RESET_VAL;
                end
            end else if (deliver) begin
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
                s_data_d  = RESET_VAL;
            end
        end
        in_ready_d = ~s_valid_d;
        kill_sum   = {1'b0, kill_cnt_q} + (CNT_W+1)'(kill_inc);
        kill_cnt_d = kill_sum[CNT_W] ? {CNT_W{1'b1}} : kill_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_q  <= 1'b0;
            m_data_q   <= RESET_VAL;
            s_valid_q  <= 1'b0;
            s_data_q   <= RESET_VAL;
            in_ready_q <= 1'b1;
            kill_cnt_q <= '0;
        end else begin
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            s_valid_q  <= s_valid_d;
            s_data_q   <= s_data_d;
            in_ready_q <= in_ready_d;
            kill_cnt_q <= kill_cnt_d;
        end
    end

    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;
    assign occupancy = {m_valid_q & s_valid_q, m_valid_q ^ s_valid_q};
    assign kill_cnt  = kill_cnt_q;

endmodule

// File: tb/tb_stage_pipe_hs.sv
// Scoreboard bench for stage_pipe_hs: skid instance, 2-bit-counter instance, pass-through instance.
module tb_stage_pipe_hs;

    localparam int W = 16;
    localparam logic [W-1:0] RV = 16'hDEAD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Instance A: skid, 16-bit counter
    logic a_flush = 0, a_trap = 0, a_in_valid = 0, a_out_ready = 0;
    logic [W-1:0] a_in_data = '0;
    logic a_in_ready, a_out_valid;
    logic [W-1:0] a_out_data;
    logic [1:0] a_occ;
    logic [15:0] a_kill;

    stage_pipe_hs #(.WIDTH(W), .RESET_VAL(RV), .SKID(1'b1), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .trap_en(a_trap),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ), .kill_cnt(a_kill));

    // Instance B: skid, 2-bit counter for saturation
    logic b_flush = 0, b_in_valid = 0;
    logic [W-1:0] b_in_data = '0;
    logic b_in_ready, b_out_valid;
    logic [W-1:0] b_out_data;
    logic [1:0] b_occ;
    logic [1:0] b_kill;

    stage_pipe_hs #(.WIDTH(W), .RESET_VAL(RV), .SKID(1'b1), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .trap_en(1'b0),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(1'b0), .out_data(b_out_data),
        .occupancy(b_occ), .kill_cnt(b_kill));

    // Instance C: no skid, combinational in_ready
    logic c_in_valid = 0, c_out_ready = 0;
    logic [W-1:0] c_in_data = '0;
    logic c_in_ready, c_out_valid;
    logic [W-1:0] c_out_data;
    logic [1:0] c_occ;
    logic [15:0] c_kill;

    stage_pipe_hs #(.WIDTH(W), .RESET_VAL(RV), .SKID(1'b0), .CNT_W(16)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .trap_en(1'b0),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .occupancy(c_occ), .kill_cnt(c_kill));

    logic [W-1:0] qa[$];
    logic [W-1:0] qc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: compare every delivered beat against the next expected one
    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) chk("a_unexpected_beat", 32'(a_out_data), 32'hFFFF_FFFF);
            else chk("a_out_data", 32'(a_out_data), 32'(qa.pop_front()));
        end
        if (rst_n && c_out_valid && c_out_ready) begin
            if (qc.size() == 0) chk("c_unexpected_beat", 32'(c_out_data), 32'hFFFF_FFFF);
            else chk("c_out_data", 32'(c_out_data), 32'(qc.pop_front()));
        end
    end

    task automatic step_a();
        #1;
        if (a_in_valid && a_in_ready && !a_flush && !a_trap) qa.push_back(a_in_data);
        @(posedge clk); #1;
        if (a_flush || (a_trap && a_out_ready)) qa.delete();
    endtask

    task automatic step_c();
        #1;
        if (c_in_valid && c_in_ready) qc.push_back(c_in_data);
        @(posedge clk); #1;
    endtask

    task automatic step_b();
        @(posedge clk); #1;
    endtask

    task automatic set_a(input logic iv, input logic [W-1:0] d, input logic ordy,
                         input logic fl, input logic tr);
        a_in_valid = iv; a_in_data = d; a_out_ready = ordy; a_flush = fl; a_trap = tr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int maxocc;
        bit saw_stall;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_data", 32'(a_out_data), 32'(RV));
        chk("rst_occupancy", 32'(a_occ), 32'd0);
        chk("rst_kill_cnt", 32'(a_kill), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);

        // T1: single beat, latency 1
        set_a(1, 16'h00A1, 1, 0, 0); step_a();
        chk("t1_out_valid", 32'(a_out_valid), 32'd1);
        chk("t1_out_data", 32'(a_out_data), 32'h00A1);
        chk("t1_occupancy", 32'(a_occ), 32'd1);
        set_a(0, 16'h0, 1, 0, 0); step_a();
        chk("t1_empty_data", 32'(a_out_data), 32'(RV));

        // T2: 8 beats, consumer stalls cycles 3..5
        sent = 0; maxocc = 0; saw_stall = 0;
        for (int c = 1; c <= 30; c++) begin
            a_out_ready = !(c >= 3 && c <= 5);
            a_in_valid  = (sent < 8);
            a_in_data   = 16'(sent + 1);
            #1;
            if (a_in_valid && a_in_ready) sent++;
            if (!a_in_ready) saw_stall = 1;
            if (int'(a_occ) > maxocc) maxocc = int'(a_occ);
            #0; step_a_wrap(c);
        end
        chk("t2_max_occupancy", 32'(maxocc), 32'd2);
        chk("t2_in_ready_low", 32'(saw_stall), 32'd1);
        chk("t2_all_sent", 32'(sent), 32'd8);
        chk("t2_drained", 32'(qa.size()), 32'd0);

        // T4: stalled trap keeps 0x33, drops 0x44
        set_a(1, 16'h0033, 0, 0, 0); step_a();
        set_a(1, 16'h0044, 0, 0, 1); step_a();
        chk("t4_kill_cnt", 32'(a_kill), 32'd1);
        chk("t4_held_data", 32'(a_out_data), 32'h0033);
        chk("t4_occupancy", 32'(a_occ), 32'd1);
        set_a(0, 16'h0, 1, 0, 1); step_a();
        chk("t4_empty_valid", 32'(a_out_valid), 32'd0);
        chk("t4_empty_occ", 32'(a_occ), 32'd0);
        chk("t4_kill_after", 32'(a_kill), 32'd1);

        // T3: flush a FULL stage with in_valid high
        set_a(1, 16'h0011, 0, 0, 0); step_a();
        set_a(1, 16'h0022, 0, 0, 0); step_a();
        chk("t3_full_occ", 32'(a_occ), 32'd2);
        chk("t3_full_in_ready", 32'(a_in_ready), 32'd0);
        set_a(1, 16'h0055, 0, 1, 0); step_a();
        chk("t3_out_valid", 32'(a_out_valid), 32'd0);
        chk("t3_out_data", 32'(a_out_data), 32'(RV));
        chk("t3_occupancy", 32'(a_occ), 32'd0);
        chk("t3_kill_cnt", 32'(a_kill), 32'd3);
        chk("t3_in_ready", 32'(a_in_ready), 32'd1);

        // Flush while delivering: delivered beat not killed, accepted beat killed
        set_a(1, 16'h0066, 0, 0, 0); step_a();
        set_a(1, 16'h0077, 1, 1, 0); step_a();
        chk("fd_kill_cnt", 32'(a_kill), 32'd4);
        chk("fd_occupancy", 32'(a_occ), 32'd0);
        set_a(1, 16'h0088, 1, 0, 0); step_a();
        set_a(0, 16'h0, 1, 0, 0); step_a();
        chk("fd_recovered", 32'(qa.size()), 32'd0);

        // T5: 2-bit counter saturates
        for (int r = 0; r < 3; r++) begin
            b_in_valid = 1; b_in_data = 16'(r); step_b();
            b_in_data = 16'(r + 8); step_b();
            b_in_valid = 0; b_flush = 1; step_b();
            b_flush = 0;
            chk("t5_kill_cnt", 32'(b_kill), (r == 0) ? 32'd2 : 32'd3);
        end
        chk("t5_occupancy", 32'(b_occ), 32'd0);

        // T6: pass-through, combinational in_ready
        c_in_valid = 1; c_in_data = 16'h0010; c_out_ready = 1; step_c();
        c_in_valid = 0; c_out_ready = 0; #1;
        chk("t6_in_ready_stall", 32'(c_in_ready), 32'd0);
        c_in_valid = 1; c_in_data = 16'h00EE; step_c();
        chk("t6_held", 32'(c_out_data), 32'h0010);
        c_out_ready = 1; #1;
        chk("t6_in_ready_go", 32'(c_in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            c_in_valid = 1; c_in_data = 16'(16'h0020 + i); step_c();
            chk("t6_rate_valid", 32'(c_out_valid), 32'd1);
        end
        c_in_valid = 0; step_c();
        chk("t6_drained", 32'(qc.size()), 32'd0);
        chk("t6_kill_cnt", 32'(c_kill), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Cycle 1 of T2 sends beat 1; acceptance is re-derived inside step_a.
    task automatic step_a_wrap(input int c);
        if (c < 0) $display("cycle %0d", c);
        step_a();
    endtask

endmodule
